// File: rtl/logit_argmax.sv
// Greedy-decode argmax over a streamed FP16 logit frame, with generation length/stop tracking.
// Optional build macro ARGMAX_TIE_LAST_EN: ties select the highest index instead of the lowest.
module logit_argmax #(
  parameter int VOCAB_SIZE = 76,
  parameter int MAX_GEN    = 4095,
  parameter int STOP_TOKEN = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          logit_valid,
  input  logic [15:0]                   logit_data,
  input  logic                          logit_last,
  output logic                          logit_ready,
  output logic                          token_valid,
  input  logic                          token_ready,
  output logic [$clog2(VOCAB_SIZE)-1:0] token,
  output logic [15:0]                   token_logit,
  output logic                          length_error,
  output logic [11:0]                   generate_count,
  output logic                          generate_complete
);

  localparam int TW = $clog2(VOCAB_SIZE);
  localparam logic [TW-1:0] LAST_IDX = TW'(VOCAB_SIZE - 1);
  localparam logic [TW-1:0] STOP_IDX = TW'(STOP_TOKEN);
  localparam logic [11:0]   MAX_CNT  = 12'(MAX_GEN);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t        state;
  logic [TW-1:0] idx;
  logic [TW-1:0] best_idx;
  logic [15:0]   best_key;
  logic [15:0]   best_logit;

  logic [15:0]   beat_key;
  logic [TW-1:0] beat_idx;
  logic          beat_wins;
  logic          accept;
  logic          at_final;
  logic          frame_end;
  logic [TW-1:0] win_idx;
  logic [15:0]   win_key;
  logic [15:0]   win_logit;
  logic [11:0]   next_count;

  // Monotonic unsigned key: negatives bit-inverted, positives get the sign bit set; NaN sinks to 0.
  function automatic logic [15:0] order_key(input logic [15:0] x);
    if (x[14:10] == 5'h1F && x[9:0] != 10'd0) return 16'h0000;
    else if (x[15])                            return ~x;
    else                                       return x ^ 16'h8000;
  endfunction

  always_comb begin
    beat_key = order_key(logit_data);
    beat_idx = (state == IDLE) ? '0 : idx;
    accept   = logit_valid && logit_ready;
    at_final = (beat_idx == LAST_IDX);
    frame_end = accept && (logit_last || at_final);
`ifdef ARGMAX_TIE_LAST_EN
    beat_wins = (state == IDLE) || (beat_key >= best_key);
`else
    beat_wins = (state == IDLE) || (beat_key > best_key);
`endif
    win_idx   = beat_wins ? beat_idx   : best_idx;
    win_key   = beat_wins ? beat_key   : best_key;
    win_logit = beat_wins ? logit_data : best_logit;
    next_count = (generate_count == MAX_CNT) ? generate_count : generate_count + 12'd1;
  end

  // Frame FSM; clear outranks every other event, and a frame end also captures the token.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      idx               <= '0;
      best_idx          <= '0;
      best_key          <= '0;
      best_logit        <= '0;
      logit_ready       <= 1'b0;
      token_valid       <= 1'b0;
      token             <= '0;
      token_logit       <= '0;
      length_error      <= 1'b0;
      generate_count    <= '0;
      generate_complete <= 1'b0;
    end else if (clear) begin
      state             <= IDLE;
      idx               <= '0;
      logit_ready       <= 1'b1;
      token_valid       <= 1'b0;
      length_error      <= 1'b0;
      generate_count    <= '0;
      generate_complete <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            best_idx   <= win_idx;
            best_key   <= win_key;
            best_logit <= win_logit;
            idx        <= beat_idx + 1'b1;
            if (frame_end) begin
              state       <= EMIT;
              logit_ready <= 1'b0;
              token_valid <= 1'b1;
              token       <= win_idx;
              token_logit <= win_logit;
              if (logit_last != at_final) length_error <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end else if (state == IDLE) begin
            logit_ready <= !generate_complete;
          end
        end
        EMIT: begin
          if (token_ready) begin
            state          <= IDLE;
            token_valid    <= 1'b0;
            generate_count <= next_count;
            if (token == STOP_IDX || next_count == MAX_CNT) begin
              generate_complete <= 1'b1;
              logit_ready       <= 1'b0;
            end else begin
              logit_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logit_argmax.sv
// Directed bench for logit_argmax: argmax ordering, ties, NaN, short frames, stop/clear, reset.
module tb_logit_argmax;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        logit_valid;
  logic [15:0] logit_data;
  logic        logit_last;
  logic        logit_ready;
  logic        token_valid;
  logic        token_ready;
  logic [6:0]  token;
  logic [15:0] token_logit;
  logic        length_error;
  logic [11:0] generate_count;
  logic        generate_complete;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] frame [76];

  always #5 clk = ~clk;

  logit_argmax dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .logit_valid(logit_valid), .logit_data(logit_data), .logit_last(logit_last),
    .logit_ready(logit_ready), .token_valid(token_valid), .token_ready(token_ready),
    .token(token), .token_logit(token_logit), .length_error(length_error),
    .generate_count(generate_count), .generate_complete(generate_complete)
  );

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 76; i++) frame[i] = v;
  endtask

  // Streams beats 0..n-1, asserting last on beat last_at; returns just after the final accepting edge.
  task automatic send_frame(input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      int   guard;
      logic acc;
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        @(negedge clk);
        logit_valid = 1'b1;
        logit_data  = frame[k];
        logit_last  = (k == last_at);
        acc = logit_ready;
        @(posedge clk);
        guard++;
        if (!acc && guard > 20) begin
          n_cmp++; n_err++;
          $display("[TB] FAIL beat_accept_timeout beat=%0d got ready=%0b need 1", k, logit_ready);
          #1 logit_valid = 1'b0; logit_last = 1'b0;
          return;
        end
      end
    end
    #1 logit_valid = 1'b0;
    logit_last = 1'b0;
  endtask

  task automatic take_token();
    @(negedge clk);
    token_ready = 1'b1;
    @(posedge clk);
    #1 token_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; logit_valid = 1'b0; logit_data = '0;
    logit_last = 1'b0; token_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (logit_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready got=%0b need 0", logit_ready); end
    n_cmp++; if (token_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got=%0b need 0", token_valid); end
    n_cmp++; if (generate_count !== 12'd0) begin n_err++; $display("[TB] FAIL reset_count got=%0d need 0", generate_count); end
    n_cmp++; if ({length_error, generate_complete} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_flags got=%b need 00", {length_error, generate_complete}); end
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (logit_ready !== 1'b1) begin n_err++; $display("[TB] FAIL post_reset_ready got=%0b need 1", logit_ready); end
  endtask

  task automatic test_peak();
    fill(16'h3C00); frame[41] = 16'h4000;
    send_frame(76, 75);
    @(negedge clk);
    n_cmp++; if (token_valid !== 1'b1) begin n_err++; $display("[TB] FAIL peak_latency got=%0b need 1", token_valid); end
    n_cmp++; if (token !== 7'd41) begin n_err++; $display("[TB] FAIL peak_token got=%0d need 41", token); end
    n_cmp++; if (token_logit !== 16'h4000) begin n_err++; $display("[TB] FAIL peak_logit got=%h need 4000", token_logit); end
    n_cmp++; if (length_error !== 1'b0) begin n_err++; $display("[TB] FAIL peak_lenerr got=%0b need 0", length_error); end
    n_cmp++; if (logit_ready !== 1'b0) begin n_err++; $display("[TB] FAIL peak_emit_ready got=%0b need 0", logit_ready); end
    take_token();
    @(negedge clk);
    n_cmp++; if (generate_count !== 12'd1) begin n_err++; $display("[TB] FAIL peak_count got=%0d need 1", generate_count); end
    n_cmp++; if ({token_valid, logit_ready} !== 2'b01) begin n_err++; $display("[TB] FAIL peak_after_hs got=%b need 01", {token_valid, logit_ready}); end
  endtask

  task automatic test_negative();
    fill(16'hC000); frame[7] = 16'hBC00;
    send_frame(76, 75);
    @(negedge clk);
    n_cmp++; if (token !== 7'd7) begin n_err++; $display("[TB] FAIL neg_token got=%0d need 7", token); end
    n_cmp++; if (token_logit !== 16'hBC00) begin n_err++; $display("[TB] FAIL neg_logit got=%h need BC00", token_logit); end
    take_token();
    fill(16'hBC00); frame[3] = 16'h8000; frame[5] = 16'h0000;
    send_frame(76, 75);
    @(negedge clk);
    n_cmp++; if (token !== 7'd5) begin n_err++; $display("[TB] FAIL zero_sign_token got=%0d need 5", token); end
    n_cmp++; if (token_logit !== 16'h0000) begin n_err++; $display("[TB] FAIL zero_sign_logit got=%h need 0000", token_logit); end
    take_token();
  endtask

  task automatic test_tie();
    logic [6:0] exp_tok;
`ifdef ARGMAX_TIE_LAST_EN
    exp_tok = 7'd20;
`else
    exp_tok = 7'd10;
`endif
    fill(16'h0000); frame[10] = 16'h4400; frame[20] = 16'h4400;
    send_frame(76, 75);
    @(negedge clk);
    n_cmp++; if (token !== exp_tok) begin n_err++; $display("[TB] FAIL tie_token got=%0d need %0d", token, exp_tok); end
    take_token();
    @(negedge clk);
    n_cmp++; if (generate_count !== 12'd4) begin n_err++; $display("[TB] FAIL tie_count got=%0d need 4", generate_count); end
  endtask

  task automatic test_short_frame();
    fill(16'h3C00); frame[12] = 16'h4200; frame[50] = 16'h4800;
    send_frame(31, 30);
    @(negedge clk);
    n_cmp++; if (length_error !== 1'b1) begin n_err++; $display("[TB] FAIL short_lenerr got=%0b need 1", length_error); end
    n_cmp++; if (token_logit !== 16'h4200) begin n_err++; $display("[TB] FAIL short_logit got=%h need 4200", token_logit); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({token_valid, logit_ready} !== 2'b10 || token !== 7'd12) begin
        n_err++;
        $display("[TB] FAIL short_hold cyc=%0d got valid=%0b ready=%0b token=%0d need 1 0 12", c, token_valid, logit_ready, token);
      end
    end
    take_token();
    @(negedge clk);
    n_cmp++; if (generate_count !== 12'd5) begin n_err++; $display("[TB] FAIL short_count got=%0d need 5", generate_count); end
  endtask

  task automatic test_stop_and_clear();
    logic [6:0] exp_tok;
    logic       exp_done;
`ifdef ARGMAX_TIE_LAST_EN
    exp_tok = 7'd75; exp_done = 1'b0;
`else
    exp_tok = 7'd0;  exp_done = 1'b1;
`endif
    fill(16'hC000); frame[2] = 16'h7E00;
    send_frame(76, 75);
    @(negedge clk);
    n_cmp++; if (token !== exp_tok) begin n_err++; $display("[TB] FAIL nan_token got=%0d need %0d", token, exp_tok); end
    n_cmp++; if (token_logit !== 16'hC000) begin n_err++; $display("[TB] FAIL nan_logit got=%h need C000", token_logit); end
    take_token();
    @(negedge clk);
    n_cmp++; if (generate_count !== 12'd6) begin n_err++; $display("[TB] FAIL stop_count got=%0d need 6", generate_count); end
    n_cmp++; if (generate_complete !== exp_done) begin n_err++; $display("[TB] FAIL stop_complete got=%0b need %0b", generate_complete, exp_done); end
    n_cmp++; if (logit_ready !== !exp_done) begin n_err++; $display("[TB] FAIL stop_ready got=%0b need %0b", logit_ready, !exp_done); end
    repeat (3) @(negedge clk);
    n_cmp++; if (logit_ready !== !exp_done) begin n_err++; $display("[TB] FAIL stop_stall got=%0b need %0b", logit_ready, !exp_done); end
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    n_cmp++; if (generate_count !== 12'd0) begin n_err++; $display("[TB] FAIL clear_count got=%0d need 0", generate_count); end
    n_cmp++; if ({generate_complete, length_error, logit_ready} !== 3'b001) begin n_err++; $display("[TB] FAIL clear_flags got=%b need 001", {generate_complete, length_error, logit_ready}); end
  endtask

  task automatic test_reset_midframe();
    fill(16'h3C00); frame[20] = 16'h5000;
    send_frame(40, -1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({token_valid, logit_ready, length_error, generate_complete} !== 4'b0000) begin n_err++; $display("[TB] FAIL midreset_flags got=%b need 0000", {token_valid, logit_ready, length_error, generate_complete}); end
    n_cmp++; if (token !== 7'd0) begin n_err++; $display("[TB] FAIL midreset_token got=%0d need 0", token); end
    reset_n = 1'b1;
    fill(16'h3C00); frame[60] = 16'h4000;
    send_frame(76, 75);
    @(negedge clk);
    n_cmp++; if (token !== 7'd60) begin n_err++; $display("[TB] FAIL fresh_token got=%0d need 60", token); end
    n_cmp++; if (token_logit !== 16'h4000) begin n_err++; $display("[TB] FAIL fresh_logit got=%h need 4000", token_logit); end
    take_token();
    @(negedge clk);
    n_cmp++; if (generate_count !== 12'd1) begin n_err++; $display("[TB] FAIL fresh_count got=%0d need 1", generate_count); end
  endtask

  initial begin
    test_reset();
    test_peak();
    test_negative();
    test_tie();
    test_short_frame();
    test_stop_and_clear();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
